wave_mixer_seq: RTL
===================

Name: wave_mixer_seq

Overview:
- Parametrised, time-multiplexed successor to the combinational wave summer.
- Snapshots NUM_VOICES unsigned voice samples on a sample strobe, then accumulates the enabled voices one per clock.
- Scales and clamps the sum, then presents a registered mixed wave with a one-cycle valid pulse.
- Sits between the per-voice oscillators and the DAC/PWM output stage.

Parameters:
- NUM_VOICES, 13, number of voice inputs (≥1).
- IN_W, 10, width of each unsigned voice sample.
- OUT_W, 14, width of mixed output.
- SHIFT, 0, right shift applied to the accumulated sum before output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- waves  in  NUM_VOICES*IN_W  packed voices; voice i at bits [i*IN_W +: IN_W].
- voice_en  in  NUM_VOICES  per-voice enable mask, snapshotted with waves.
- sample_tick  in  1  single-cycle request to start a mix.
- overrun_clr  in  1  clears sticky overrun.
- wave  out  OUT_W  mixed output, held between updates.
- out_valid  out  1  one-cycle pulse when wave updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky: sample_tick arrived while not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - wave=0, out_valid=0, busy=0, overrun=0.
  - State IDLE; accumulator, index and snapshot cleared.
  - Reset mid-mix aborts the mix with no out_valid.
- Accumulator width: ACC_W = IN_W + clog2(NUM_VOICES). It never wraps.
- States: IDLE, ACCUM, DONE. busy=1 in ACCUM and DONE.
- IDLE:
  - sample_tick=1 at edge E0: capture waves and voice_en into snapshot registers; acc←0; idx←0; go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM, edges E1..E(NUM_VOICES):
  - acc ← acc + (snap_en[idx] ? snap_wave[idx] : 0); idx←idx+1.
  - At the edge where idx==NUM_VOICES-1, go to DONE.
- DONE, edge E(NUM_VOICES+1):
  - wave ← result; out_valid←1 for exactly one cycle; go to IDLE.
- Latency: out_valid is high in the cycle after edge E(NUM_VOICES+1). That is 14 cycles after the tick edge at defaults.
- Input stability: inputs may change freely after E0. The result uses the snapshot only.
- Result: r = acc >> SHIFT. If r fits in OUT_W bits, wave=r. Otherwise see Optional Feature.
- Back-to-back: sample_tick is accepted in the cycle out_valid is high, because the state is IDLE then. The maximum mix rate is one per NUM_VOICES+2 cycles.
- Overrun:
  - sample_tick while state≠IDLE sets overrun=1. The tick is ignored and the current mix is unaffected.
  - overrun_clr=1 clears overrun. If set and clear occur in the same cycle, set wins.
- All voices disabled: wave=0 with a normal out_valid pulse.
- Default parameters give exactly the legacy sum: 13×1023=13299 < 2^14.

Optional Feature:
- Macro: WAVE_MIXER_SATURATE_EN.
- Defined: if r > 2^OUT_W−1, wave = 2^OUT_W−1 (clamp).
- Undefined: wave = r[OUT_W-1:0] (silent wrap). There is no extra logic.
- Neither mode affects timing or flags.

Test Plan:
- Defaults, all waves=1023, voice_en=all ones, one tick → out_valid 14 cycles after tick, wave=13299, busy high for 13+1 cycles, overrun=0.
- voice_en=0x0005, voice0=100, voice2=200, others=1000 → wave=300. Then voice_en=0 and tick → wave=0 with out_valid.
- Tick, then change all waves to 0 at E1 → wave reflects the snapshot values, not 0.
- Second tick 5 cycles after the first → overrun=1, first result correct, no second out_valid. overrun_clr pulse → overrun=0. Tick in the out_valid cycle → accepted, no overrun.
- OUT_W=12, all 1023 enabled → with macro wave=4095; without macro wave=13299 mod 4096=1011. SHIFT=2, defaults → wave=3324.
- rst_n low for 1 cycle at E5 of a mix → wave=0, busy=0, no out_valid. A fresh tick afterwards gives a correct result.

Source files
------------

// File: rtl/wave_mixer_seq.sv
// wave_mixer_seq: time-multiplexed voice mixer, one voice per clock.
// Optional clamp to full scale when WAVE_MIXER_SATURATE_EN is defined.
module wave_mixer_seq #(
  parameter int NUM_VOICES = 13,
  parameter int IN_W       = 10,
  parameter int OUT_W      = 14,
  parameter int SHIFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VOICES*IN_W-1:0] waves,
  input  logic [NUM_VOICES-1:0]      voice_en,
  input  logic                       sample_tick,
  input  logic                       overrun_clr,
  output logic [OUT_W-1:0]           wave,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W = IN_W + $clog2(NUM_VOICES);
  localparam int IDX_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IN_W-1:0]       r_snap_wave [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_snap_en;
  logic [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic [OUT_W-1:0]      r_wave;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_ovr;

  logic [IN_W-1:0]       w_term;
  logic [ACC_W-1:0]      w_shr;
  logic [OUT_W-1:0]      w_result;

  assign w_term = r_snap_en[r_idx] ? r_snap_wave[r_idx] : '0;
  assign w_shr  = r_acc >> SHIFT;

`ifdef WAVE_MIXER_SATURATE_EN
  localparam int RW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [RW-1:0] MAXV = RW'({OUT_W{1'b1}});

  assign w_result = (RW'(w_shr) > MAXV) ? '1 : OUT_W'(w_shr);
`else
  assign w_result = OUT_W'(w_shr);
`endif

  assign wave      = r_wave;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_ovr;

  // Mix FSM: snapshot on tick, accumulate one voice per clock, publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      r_snap_en <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_snap_wave[i] <= '0;
      end
      r_wave    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (sample_tick && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end else if (overrun_clr) begin
        r_ovr <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              r_snap_wave[i] <= waves[i*IN_W +: IN_W];
            end
            r_snap_en <= voice_en;
            r_acc     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + ACC_W'(w_term);
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_wave  <= w_result;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
